// File: rtl/rom_map_pkg.sv
// Shared types and helpers for the ROM bank mapper / DDRAM bridge.
package rom_map_pkg;

  localparam int DEF_BANK_W = 6;

  typedef logic [DEF_BANK_W-1:0] bank_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  // Bank i initially maps onto itself, truncated to the register width.
  function automatic logic [31:0] map_reset_value(input int unsigned i, input int unsigned w);
    return 32'(i) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_bank_regs.sv
// Bank window registers, SRAM-enable bit and CPU-to-DDRAM address translation.
module rom_bank_regs
  import rom_map_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BANK_W    = 6,
  parameter int WIN_W     = 16,
  parameter int CPU_AW    = 20,
  parameter int LINE_SH   = 3,
  parameter int DDR_AW    = 25,
  localparam int IDX_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              map_we,
  input  logic [IDX_W-1:0]  map_a,
  input  logic [BANK_W-1:0] map_d,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic              sram_en,
  output logic [DDR_AW-1:0] phys
);

  localparam int MAP_W = BANK_W + WIN_W;
  localparam int EXT_W = ((MAP_W > CPU_AW) ? MAP_W : CPU_AW) + LINE_SH;

  logic [BANK_W-1:0] banks_q [NUM_BANKS];
  logic [BANK_W-1:0] banks_d [NUM_BANKS];
  logic              use_map_q, use_map_d;
  logic              sram_en_q, sram_en_d;

  always_comb begin
    banks_d   = banks_q;
    use_map_d = use_map_q;
    sram_en_d = sram_en_q;
    if (map_we) begin
      // Index 0 is the SRAM-enable register, not a bank window.
      if (map_a == '0) begin
        sram_en_d = map_d[0];
      end else begin
        banks_d[map_a] = map_d;
        use_map_d      = 1'b1;
      end
    end
  end

  // NOTE: the bank file is a few flops with defined power-up mapping, so it is reset; a large RAM would not be.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        banks_q[i] <= BANK_W'(map_reset_value(i, BANK_W));
      end
      use_map_q <= 1'b0;
      sram_en_q <= 1'b0;
    end else begin
      banks_q   <= banks_d;
      use_map_q <= use_map_d;
      sram_en_q <= sram_en_d;
    end
  end

  logic [IDX_W-1:0] bank;
  logic [MAP_W-1:0] mapped;
  logic [EXT_W-1:0] logical;

  assign bank    = cpu_addr[WIN_W+IDX_W-1:WIN_W];
  assign mapped  = {banks_q[bank], cpu_addr[WIN_W-1:0]};
  assign logical = use_map_q ? EXT_W'(mapped) : EXT_W'(cpu_addr);
  assign phys    = DDR_AW'(logical << LINE_SH);
  assign sram_en = sram_en_q;

endmodule

// File: rtl/rom_map_bridge.sv
// CPU ROM read path (one-line cache, single outstanding DDRAM read) and HPS download writes.
module rom_map_bridge
  import rom_map_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BANK_W    = 6,
  parameter int WIN_W     = 16,
  parameter int CPU_AW    = 20,
  parameter int LINE_SH   = 3,
  parameter int DDR_AW    = 25,
  parameter int DL_AW     = 25,
  localparam int IDX_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              map_we,
  input  logic [IDX_W-1:0]  map_a,
  input  logic [BANK_W-1:0] map_d,
  output logic              sram_en,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic              cpu_req,
  output logic              cpu_ack,
  output logic [63:0]       cpu_data,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [DL_AW-1:0]  dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  output logic [DDR_AW-1:0] ddr_addr,
  output logic [15:0]       ddr_din,
  output logic              ddr_we_req,
  input  logic              ddr_we_ack,
  output logic              ddr_rd_req,
  input  logic              ddr_rd_ack,
  input  logic [63:0]       ddr_dout
);

  logic [DDR_AW-1:0] phys;

  rom_bank_regs #(
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W),
    .WIN_W     (WIN_W),
    .CPU_AW    (CPU_AW),
    .LINE_SH   (LINE_SH),
    .DDR_AW    (DDR_AW)
  ) u_bank_regs (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .map_we   (map_we),
    .map_a    (map_a),
    .map_d    (map_d),
    .cpu_addr (cpu_addr),
    .sram_en  (sram_en),
    .phys     (phys)
  );

  rd_state_t         state_q, state_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [63:0]       cpu_data_q, cpu_data_d;
  logic [DDR_AW-1:0] ddr_addr_q, ddr_addr_d;
  logic [15:0]       ddr_din_q, ddr_din_d;
  logic              ddr_we_req_q, ddr_we_req_d;
  logic              ddr_rd_req_q, ddr_rd_req_d;
  logic              dl_wait_q, dl_wait_d;
  logic              cache_valid_q, cache_valid_d;
  logic [DDR_AW-1:0] cache_addr_q, cache_addr_d;
  logic [63:0]       cache_data_q, cache_data_d;
  logic              stale_q, stale_d;
  logic              dl_prev_q;

  logic dl_rise, pending, stale_now;

  assign dl_rise   = dl_active & ~dl_prev_q;
  assign pending   = cpu_req != cpu_ack_q;
  assign stale_now = stale_q | map_we | dl_rise;
  // A read still in flight owns ddr_addr, so a starting download is held off.
  assign dl_wait   = dl_wait_q | ((state_q == RD_WAIT) & dl_active);

  // NOTE: every _d takes its _q value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cpu_ack_d     = cpu_ack_q;
    cpu_data_d    = cpu_data_q;
    ddr_addr_d    = ddr_addr_q;
    ddr_din_d     = ddr_din_q;
    ddr_we_req_d  = ddr_we_req_q;
    ddr_rd_req_d  = ddr_rd_req_q;
    dl_wait_d     = dl_wait_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    stale_d       = stale_q;

    unique case (state_q)
      IDLE: begin
        if (pending && !dl_active) begin
          if (cache_valid_q && (phys == cache_addr_q)) begin
            cpu_data_d = cache_data_q;
            cpu_ack_d  = cpu_req;
          end else begin
            ddr_addr_d   = phys;
            ddr_rd_req_d = ~ddr_rd_req_q;
            stale_d      = 1'b0;
            state_d      = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (ddr_rd_ack == ddr_rd_req_q) begin
          cpu_data_d = ddr_dout;
          cpu_ack_d  = cpu_req;
          if (!stale_now) begin
            cache_data_d  = ddr_dout;
            cache_addr_d  = ddr_addr_q;
            cache_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          stale_d = stale_now;
        end
      end
      default: state_d = IDLE;
    endcase

    if (map_we) cache_valid_d = 1'b0;

    if (dl_wait_q && (ddr_we_ack == ddr_we_req_q)) dl_wait_d = 1'b0;

    if (dl_rise) begin
      ddr_we_req_d  = 1'b0;
      cache_valid_d = 1'b0;
    end else if (dl_wr && dl_active && !dl_wait) begin
      ddr_addr_d   = DDR_AW'(dl_addr);
      ddr_din_d    = {dl_data[7:0], dl_data[15:8]};
      ddr_we_req_d = ~ddr_we_req_q;
      dl_wait_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses <= only; the combinational block above uses = only.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cpu_ack_q     <= 1'b0;
      cpu_data_q    <= '0;
      ddr_addr_q    <= '0;
      ddr_din_q     <= '0;
      ddr_we_req_q  <= 1'b0;
      ddr_rd_req_q  <= 1'b0;
      dl_wait_q     <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      stale_q       <= 1'b0;
      dl_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_data_q    <= cpu_data_d;
      ddr_addr_q    <= ddr_addr_d;
      ddr_din_q     <= ddr_din_d;
      ddr_we_req_q  <= ddr_we_req_d;
      ddr_rd_req_q  <= ddr_rd_req_d;
      dl_wait_q     <= dl_wait_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      stale_q       <= stale_d;
      dl_prev_q     <= dl_active;
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_data   = cpu_data_q;
  assign ddr_addr   = ddr_addr_q;
  assign ddr_din    = ddr_din_q;
  assign ddr_we_req = ddr_we_req_q;
  assign ddr_rd_req = ddr_rd_req_q;

endmodule
